dyn_branch_control: RTL and testbench

- Next-generation front-end branch decision block.
- Decodes the same 2-bit branch class as the static controller: 00 CC, 01 B, 10 BL, 11 BX.
- Adds a parametrised pattern history table (PHT) of saturating counters for conditional branches, plus a return address stack (RAS) that predicts BX targets.
- Sits in FE between fetch/decode and the PC mux. Execute feeds back resolved conditional outcomes.

---
 rtl/dyn_branch_control.sv | 157 +++++++++++++++
 tb/tb_dyn_branch_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dyn_branch_control.sv
// Front-end branch decision: decodes the branch class, predicts conditional branches
// from a saturating-counter pattern history table and BX targets from a return address stack.
module dyn_branch_control #(
  parameter int IDX_W     = 6,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 8,
  parameter int ADDR_W    = 16,
  parameter int DYNAMIC   = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pred_v_i,
  input  logic              is_branch_i,
  input  logic              sign_bit_i,
  input  logic [1:0]        branch_op_code_i,
  input  logic [IDX_W-1:0]  pc_idx_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  input  logic              upd_v_i,
  input  logic [IDX_W-1:0]  upd_idx_i,
  input  logic              upd_taken_i,
  input  logic              flush_i,
  output logic              pred_v_o,
  output logic              take_branch_o,
  output logic              speculative_o,
  output logic              br_link,
  output logic              br_ex,
  output logic [ADDR_W-1:0] ras_target_o,
  output logic              ras_valid_o
);

  localparam int PHT_N = 2 ** IDX_W;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [1:0] OP_CC = 2'b00;
  localparam logic [1:0] OP_B  = 2'b01;
  localparam logic [1:0] OP_BL = 2'b10;

  logic [CTR_W-1:0]  pht_q [PHT_N];
  logic [CTR_W-1:0]  pht_d [PHT_N];
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pred_v_q, pred_v_d;
  logic              take_q, take_d;
  logic              spec_q, spec_d;
  logic              link_q, link_d;
  logic              ex_q, ex_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              tgt_v_q, tgt_v_d;
  logic              req;
  logic [CTR_W-1:0]  rd_ctr;

  // Resolved outcomes train the table regardless of requests or flushes.
  always_comb begin
    pht_d = pht_q;
    if (upd_v_i) begin
      if (upd_taken_i) begin
        if (pht_q[upd_idx_i] != CTR_MAX) pht_d[upd_idx_i] = pht_q[upd_idx_i] + 1'b1;
      end else if (pht_q[upd_idx_i] != '0) begin
        pht_d[upd_idx_i] = pht_q[upd_idx_i] - 1'b1;
      end
    end
  end

  // Prediction reads the registered table, so a same-cycle update is not seen.
  always_comb begin
    req      = pred_v_i & ~flush_i;
    rd_ctr   = pht_q[pc_idx_i];
    ptr_dec  = ptr_q - 1'b1;
    ras_d    = ras_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    pred_v_d = req;
    take_d   = 1'b0;
    spec_d   = 1'b0;
    link_d   = 1'b0;
    ex_d     = 1'b0;
    tgt_d    = '0;
    tgt_v_d  = 1'b0;
    if (req && is_branch_i) begin
      case (branch_op_code_i)
        OP_CC: begin
          spec_d = 1'b1;
          take_d = (DYNAMIC != 0) ? rd_ctr[CTR_W-1] : sign_bit_i;
        end
        OP_B: take_d = 1'b1;
        OP_BL: begin
          take_d        = 1'b1;
          spec_d        = 1'b1;
          link_d        = 1'b1;
          ras_d[ptr_q]  = ret_addr_i;
          ptr_d         = ptr_q + 1'b1;
          if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
        end
        default: begin
          take_d = 1'b1;
          spec_d = 1'b1;
          ex_d   = 1'b1;
          if (cnt_q != '0) begin
            tgt_v_d = 1'b1;
            tgt_d   = ras_q[ptr_dec];
            ptr_d   = ptr_dec;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      endcase
    end
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
      ptr_q    <= '0;
      cnt_q    <= '0;
      pred_v_q <= 1'b0;
      take_q   <= 1'b0;
      spec_q   <= 1'b0;
      link_q   <= 1'b0;
      ex_q     <= 1'b0;
      tgt_q    <= '0;
      tgt_v_q  <= 1'b0;
    end else begin
      pht_q    <= pht_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      pred_v_q <= pred_v_d;
      take_q   <= take_d;
      spec_q   <= spec_d;
      link_q   <= link_d;
      ex_q     <= ex_d;
      tgt_q    <= tgt_d;
      tgt_v_q  <= tgt_v_d;
    end
  end

  // Stack storage is only meaningful below the count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    ras_q <= ras_d;
  end

  assign pred_v_o      = pred_v_q;
  assign take_branch_o = take_q;
  assign speculative_o = spec_q;
  assign br_link       = link_q;
  assign br_ex         = ex_q;
  assign ras_target_o  = tgt_q;
  assign ras_valid_o   = tgt_v_q;

endmodule

// File: tb/tb_dyn_branch_control.sv
// Directed bench: a dynamic instance (4-entry RAS) and a static instance share the stimulus.
module tb_dyn_branch_control;

  localparam int IDX_W     = 6;
  localparam int CTR_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int ADDR_W    = 16;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              pred_v_i, is_branch_i, sign_bit_i;
  logic [1:0]        branch_op_code_i;
  logic [IDX_W-1:0]  pc_idx_i;
  logic [ADDR_W-1:0] ret_addr_i;
  logic              upd_v_i;
  logic [IDX_W-1:0]  upd_idx_i;
  logic              upd_taken_i;
  logic              flush_i;

  logic              d_pred_v, d_take, d_spec, d_link, d_ex, d_tv;
  logic [ADDR_W-1:0] d_tgt;
  logic              s_pred_v, s_take, s_spec, s_link, s_ex, s_tv;
  logic [ADDR_W-1:0] s_tgt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dyn_branch_control #(.IDX_W(IDX_W), .CTR_W(CTR_W), .RAS_DEPTH(RAS_DEPTH),
                       .ADDR_W(ADDR_W), .DYNAMIC(1)) u_dyn (
    .clk_i(clk), .reset_i(reset_i), .pred_v_i(pred_v_i), .is_branch_i(is_branch_i),
    .sign_bit_i(sign_bit_i), .branch_op_code_i(branch_op_code_i), .pc_idx_i(pc_idx_i),
    .ret_addr_i(ret_addr_i), .upd_v_i(upd_v_i), .upd_idx_i(upd_idx_i),
    .upd_taken_i(upd_taken_i), .flush_i(flush_i), .pred_v_o(d_pred_v),
    .take_branch_o(d_take), .speculative_o(d_spec), .br_link(d_link), .br_ex(d_ex),
    .ras_target_o(d_tgt), .ras_valid_o(d_tv));

  dyn_branch_control #(.IDX_W(IDX_W), .CTR_W(CTR_W), .RAS_DEPTH(RAS_DEPTH),
                       .ADDR_W(ADDR_W), .DYNAMIC(0)) u_sta (
    .clk_i(clk), .reset_i(reset_i), .pred_v_i(pred_v_i), .is_branch_i(is_branch_i),
    .sign_bit_i(sign_bit_i), .branch_op_code_i(branch_op_code_i), .pc_idx_i(pc_idx_i),
    .ret_addr_i(ret_addr_i), .upd_v_i(upd_v_i), .upd_idx_i(upd_idx_i),
    .upd_taken_i(upd_taken_i), .flush_i(flush_i), .pred_v_o(s_pred_v),
    .take_branch_o(s_take), .speculative_o(s_spec), .br_link(s_link), .br_ex(s_ex),
    .ras_target_o(s_tgt), .ras_valid_o(s_tv));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pred_v_i = 0; is_branch_i = 0; sign_bit_i = 0; branch_op_code_i = 2'b00;
    pc_idx_i = '0; ret_addr_i = '0; upd_v_i = 0; upd_idx_i = '0; upd_taken_i = 0;
    flush_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves any already-set update/flush inputs in place for the same cycle.
  task automatic req(input logic [1:0] op, input logic sign, input logic [IDX_W-1:0] idx,
                     input logic [ADDR_W-1:0] ret);
    pred_v_i = 1; is_branch_i = 1; branch_op_code_i = op; sign_bit_i = sign;
    pc_idx_i = idx; ret_addr_i = ret;
    tick();
    idle();
  endtask

  task automatic upd(input logic [IDX_W-1:0] idx, input logic taken);
    upd_v_i = 1; upd_idx_i = idx; upd_taken_i = taken;
    tick();
    idle();
  endtask

  // {pred_v, take, spec, link, ex}
  function automatic logic [4:0] dflags();
    return {d_pred_v, d_take, d_spec, d_link, d_ex};
  endfunction

  function automatic logic [3:0] sflags();
    return {s_take, s_spec, s_link, s_ex};
  endfunction

  initial begin
    idle();
    reset_i = 1;
    #3;
    check_eq("reset_flags", {27'd0, dflags()}, 32'h0);
    check_eq("reset_ras", {15'd0, d_tv, d_tgt}, 32'h0);
    #10;
    reset_i = 0;
    tick();

    // Static parity, with the dynamic instance alongside
    req(2'b00, 1'b1, 6'd0, 16'h0);
    check_eq("static_cc_back", {28'd0, sflags()}, 32'hC);
    check_eq("dyn_cc_init", {27'd0, dflags()}, 32'h14);
    req(2'b00, 1'b0, 6'd0, 16'h0);
    check_eq("static_cc_fwd", {28'd0, sflags()}, 32'h4);
    req(2'b01, 1'b0, 6'd0, 16'h0);
    check_eq("static_b", {28'd0, sflags()}, 32'h8);
    req(2'b10, 1'b0, 6'd0, 16'h0100);
    check_eq("static_bl", {28'd0, sflags()}, 32'hE);
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("static_bx", {28'd0, sflags()}, 32'hD);
    check_eq("static_bx_tgt", {15'd0, s_tv, s_tgt}, 32'h1_0100);
    check_eq("dyn_bx_flags", {27'd0, dflags()}, 32'h1D);

    // Counter training at index 5
    req(2'b00, 1'b0, 6'd5, 16'h0);
    check_eq("train_init", {31'd0, d_take}, 32'h0);
    upd(6'd5, 1'b1);
    check_eq("upd_no_pred_v", {31'd0, d_pred_v}, 32'h0);
    upd(6'd5, 1'b1);
    req(2'b00, 1'b0, 6'd5, 16'h0);
    check_eq("train_taken", {31'd0, d_take}, 32'h1);
    upd(6'd5, 1'b1);
    upd(6'd5, 1'b1);
    upd(6'd5, 1'b0);
    req(2'b00, 1'b0, 6'd5, 16'h0);
    check_eq("train_sat_hi", {31'd0, d_take}, 32'h1);
    upd(6'd5, 1'b0);
    req(2'b00, 1'b0, 6'd5, 16'h0);
    check_eq("train_not_taken", {31'd0, d_take}, 32'h0);

    // Low saturation at index 7: 1 -> 0 -> 0, then two taken -> 2
    upd(6'd7, 1'b0);
    upd(6'd7, 1'b0);
    upd(6'd7, 1'b1);
    upd(6'd7, 1'b1);
    req(2'b00, 1'b0, 6'd7, 16'h0);
    check_eq("train_sat_lo", {31'd0, d_take}, 32'h1);

    // Same-index read and update in one cycle
    upd_v_i = 1; upd_idx_i = 6'd3; upd_taken_i = 1;
    req(2'b00, 1'b0, 6'd3, 16'h0);
    check_eq("bypass_old", {31'd0, d_take}, 32'h0);
    req(2'b00, 1'b0, 6'd3, 16'h0);
    check_eq("bypass_new", {31'd0, d_take}, 32'h1);

    // RAS LIFO and underflow
    req(2'b10, 1'b0, 6'd0, 16'h0100);
    req(2'b10, 1'b0, 6'd0, 16'h0200);
    check_eq("bl_flags", {27'd0, dflags()}, 32'h1E);
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("lifo_pop1", {15'd0, d_tv, d_tgt}, 32'h1_0200);
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("lifo_pop2", {15'd0, d_tv, d_tgt}, 32'h1_0100);
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("lifo_under", {15'd0, d_tv, d_tgt}, 32'h0);

    // RAS overflow with 4 entries
    for (int i = 1; i <= 5; i++) req(2'b10, 1'b0, 6'd0, 16'(i * 16));
    for (int i = 5; i >= 1; i--) begin
      req(2'b11, 1'b0, 6'd0, 16'h0);
      if (i > 1) check_eq("ovf_pop", {15'd0, d_tv, d_tgt}, {15'd0, 1'b1, 16'(i * 16)});
      else       check_eq("ovf_under", {15'd0, d_tv, d_tgt}, 32'h0);
    end

    // Flush cancels a BX, clears the stack, and keeps a same-cycle update
    req(2'b10, 1'b0, 6'd0, 16'hAAAA);
    req(2'b10, 1'b0, 6'd0, 16'hBBBB);
    flush_i = 1; upd_v_i = 1; upd_idx_i = 6'd9; upd_taken_i = 1;
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("flush_outs", {10'd0, dflags(), d_tv, d_tgt}, 32'h0);
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("flush_cleared", {15'd0, d_tv, d_tgt}, 32'h0);
    req(2'b00, 1'b0, 6'd9, 16'h0);
    check_eq("flush_upd_kept", {31'd0, d_take}, 32'h1);

    // Asynchronous reset mid-stream
    req(2'b10, 1'b0, 6'd0, 16'h1234);
    check_eq("pre_reset", {27'd0, dflags()}, 32'h1E);
    reset_i = 1;
    #1;
    check_eq("reset_async", {10'd0, dflags(), d_tv, d_tgt}, 32'h0);
    #1;
    reset_i = 0;
    req(2'b00, 1'b0, 6'd3, 16'h0);
    check_eq("reset_pht", {27'd0, dflags()}, 32'h14);
    req(2'b11, 1'b0, 6'd0, 16'h0);
    check_eq("reset_ras", {15'd0, d_tv, d_tgt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
